// File: rtl/hex_scan_ctrl.sv
// Bus-mapped 4-digit seven-segment controller: digit/enable/blink registers,
// internal anode scan, blink timer and soft clear; all outputs registered.
module hex_scan_ctrl #(
   parameter int SCAN_DIV  = 100000,
   parameter int BLINK_DIV = 50000000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] wdata_i,
   input  logic [31:0] addr_i,
   input  logic [3:0]  be_i,
   input  logic        we_i,
   output logic [31:0] rdata_o,
   output logic [6:0]  seg_o,
   output logic [3:0]  an_o
);

   localparam int SW = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
   localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   localparam logic [1:0] A_DIGITS = 2'd0;
   localparam logic [1:0] A_EN     = 2'd1;
   localparam logic [1:0] A_BLINK  = 2'd2;
   localparam logic [1:0] A_CTRL   = 2'd3;

   logic [15:0]   digits;
   logic [3:0]    en;
   logic [3:0]    blink;
   logic [SW-1:0] presc;
   logic [BW-1:0] bcnt;
   logic [1:0]    idx;
   logic          blink_phase;

   logic          wr_dig, wr_en, wr_blink, soft_clr;
   logic          scan_tc, blink_tc, blank;
   logic [3:0]    cur_digit;
   logic [31:0]   rd_next;

   // Address bits and byte lanes that the register map never looks at.
   logic unused_bits;
   assign unused_bits = ^{addr_i[31:4], addr_i[1:0], wdata_i[31:16], be_i[3:2]};

   function automatic logic [6:0] hex_decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   assign wr_dig   = we_i && (addr_i[3:2] == A_DIGITS);
   assign wr_en    = we_i && (addr_i[3:2] == A_EN)    && be_i[0];
   assign wr_blink = we_i && (addr_i[3:2] == A_BLINK) && be_i[0];
   assign soft_clr = we_i && (addr_i[3:2] == A_CTRL)  && be_i[0] && wdata_i[0];

   assign scan_tc   = (presc == SCAN_LAST);
   assign blink_tc  = (bcnt == BLINK_LAST);
   assign cur_digit = digits[{idx, 2'b00} +: 4];
   assign blank     = !en[idx] || (blink[idx] && !blink_phase);

   always_comb begin
      rd_next = 32'h0;
      case (addr_i[3:2])
         A_DIGITS: rd_next = {16'h0, digits};
         A_EN:     rd_next = {28'h0, en};
         A_BLINK:  rd_next = {28'h0, blink};
         default:  rd_next = 32'h0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         digits      <= 16'h0;
         en          <= 4'hF;
         blink       <= 4'h0;
         presc       <= '0;
         bcnt        <= '0;
         idx         <= 2'd0;
         blink_phase <= 1'b1;
         an_o        <= 4'hF;
         seg_o       <= 7'h7F;
         rdata_o     <= 32'h0;
      end else begin
         // Outputs always reflect the state held before this edge.
         an_o    <= blank ? 4'hF  : ~(4'b0001 << idx);
         seg_o   <= blank ? 7'h7F : hex_decode(cur_digit);
         rdata_o <= rd_next;

         if (soft_clr) begin
            digits      <= 16'h0;
            en          <= 4'hF;
            blink       <= 4'h0;
            presc       <= '0;
            bcnt        <= '0;
            idx         <= 2'd0;
            blink_phase <= 1'b1;
         end else begin
            presc <= scan_tc ? '0 : presc + 1'b1;
            if (scan_tc)
               idx <= idx + 2'd1;
            bcnt <= blink_tc ? '0 : bcnt + 1'b1;
            if (blink_tc)
               blink_phase <= !blink_phase;
            if (wr_dig && be_i[0])
               digits[7:0] <= wdata_i[7:0];
            if (wr_dig && be_i[1])
               digits[15:8] <= wdata_i[15:8];
            if (wr_en)
               en <= wdata_i[3:0];
            if (wr_blink)
               blink <= wdata_i[3:0];
         end
      end
   end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Randomized bench for hex_scan_ctrl against a cycle-count based display model.
module tb_hex_scan_ctrl;

   localparam int SD = 4;
   localparam int BD = 16;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [31:0] wdata_i, addr_i;
   logic [3:0]  be_i;
   logic        we_i;
   logic [31:0] rdata_o;
   logic [6:0]  seg_o;
   logic [3:0]  an_o;

   hex_scan_ctrl #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .wdata_i(wdata_i), .addr_i(addr_i),
      .be_i(be_i), .we_i(we_i), .rdata_o(rdata_o), .seg_o(seg_o), .an_o(an_o)
   );

   always #5 clk_i = ~clk_i;

   // Model: register contents plus cycles elapsed since the last reset/clear.
   logic [15:0] m_dig;
   logic [3:0]  m_en, m_blink;
   int          m_t;
   logic [3:0]  exp_an;
   logic [6:0]  exp_seg;
   logic [31:0] exp_rd;
   int          vectors = 0;
   int          miscompares = 0;

   function automatic logic [6:0] hexd(input logic [3:0] v);
      logic [6:0] t [16];
      t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      return t[v];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0d)", name, act, exp, m_t);
      end
   endtask

   task automatic model_reset();
      m_dig = 16'h0; m_en = 4'hF; m_blink = 4'h0; m_t = 0;
   endtask

   task automatic tick();
      int  idx;
      bit  vis, blank;
      @(posedge clk_i);
      if (!rst_ni) begin
         model_reset();
         exp_an = 4'hF; exp_seg = 7'h7F; exp_rd = 32'h0;
      end else begin
         idx   = (m_t / SD) % 4;
         vis   = ((m_t / BD) % 2) == 0;
         blank = !m_en[idx] || (m_blink[idx] && !vis);
         exp_an  = blank ? 4'hF : ~(4'b0001 << idx);
         exp_seg = blank ? 7'h7F : hexd(4'(m_dig >> (4 * idx)));
         case (addr_i[3:2])
            2'd0: exp_rd = {16'h0, m_dig};
            2'd1: exp_rd = {28'h0, m_en};
            2'd2: exp_rd = {28'h0, m_blink};
            default: exp_rd = 32'h0;
         endcase
         if (we_i && addr_i[3:2] == 2'd3 && be_i[0] && wdata_i[0]) begin
            model_reset();
         end else begin
            m_t++;
            if (we_i) begin
               case (addr_i[3:2])
                  2'd0: begin
                     if (be_i[0]) m_dig[7:0]  = wdata_i[7:0];
                     if (be_i[1]) m_dig[15:8] = wdata_i[15:8];
                  end
                  2'd1: if (be_i[0]) m_en    = wdata_i[3:0];
                  2'd2: if (be_i[0]) m_blink = wdata_i[3:0];
                  default: ;
               endcase
            end
         end
      end
      @(negedge clk_i);
      chk("an_o",    {28'h0, an_o},  {28'h0, exp_an});
      chk("seg_o",   {25'h0, seg_o}, {25'h0, exp_seg});
      chk("rdata_o", rdata_o,        exp_rd);
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
      we_i = 1'b1; addr_i = {28'h0, a}; wdata_i = d; be_i = be;
      tick();
      we_i = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst_ni = 1'b0; we_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0; be_i = 4'h0;
      model_reset();
      @(negedge clk_i);

      // Reset hold
      idle(3);
      chk("rst_an",  {28'h0, an_o},  32'hF);
      chk("rst_seg", {25'h0, seg_o}, 32'h7F);
      chk("rst_rd",  rdata_o,        32'h0);

      // Release and scan
      rst_ni = 1'b1;
      tick();
      chk("scan0_an",  {28'h0, an_o},  32'hE);
      chk("scan0_seg", {25'h0, seg_o}, 32'h40);
      idle(4);
      chk("scan1_an",  {28'h0, an_o},  32'hD);
      idle(12);

      // Decode and byte enables
      wr(4'h0, 32'h0000A1F8, 4'b0011);
      addr_i = 32'h0;
      tick();
      chk("dig_rd", rdata_o, 32'h0000A1F8);
      idle(16);
      wr(4'h0, 32'h00005500, 4'b0010);
      tick();
      chk("dig_be_rd", rdata_o, 32'h000055F8);

      // Enable mask
      wr(4'h4, 32'h5, 4'b0001);
      addr_i = 32'h4;
      idle(20);
      chk("en_rd", rdata_o, 32'h5);

      // Blink digit 0
      wr(4'h4, 32'hF, 4'b0001);
      wr(4'h8, 32'h1, 4'b0001);
      idle(70);

      // Soft clear at idx 2
      for (int i = 0; i < 16 && ((m_t / SD) % 4) != 2; i++) tick();
      chk("sc_idx2_reached", ((m_t / SD) % 4), 2);
      wr(4'hC, 32'h1, 4'b0001);
      addr_i = 32'hC;
      tick();
      chk("sc_an",  {28'h0, an_o},  32'hE);
      chk("sc_seg", {25'h0, seg_o}, 32'h40);
      chk("sc_rd",  rdata_o,        32'h0);

      // DIGITS write on scan terminal-count edge (clear left t=1, so t=3 is two ticks away)
      idle(2);
      wr(4'h0, 32'h00004321, 4'b0011);
      tick();
      chk("col_an",  {28'h0, an_o},  32'hD);
      chk("col_seg", {25'h0, seg_o}, 32'h24);

      // Reset during blink-off phase
      wr(4'h8, 32'hF, 4'b0001);
      for (int i = 0; i < 40 && ((m_t / BD) % 2) == 0; i++) tick();
      rst_ni = 1'b0;
      tick();
      chk("mrst_an",  {28'h0, an_o},  32'hF);
      chk("mrst_seg", {25'h0, seg_o}, 32'h7F);
      chk("mrst_rd",  rdata_o,        32'h0);
      rst_ni = 1'b1;
      tick();
      chk("mrst_an1", {28'h0, an_o}, 32'hE);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst_ni  = ($urandom_range(0, 399) != 0);
         we_i    = ($urandom_range(0, 3) == 0);
         addr_i  = $urandom;
         wdata_i = $urandom;
         be_i    = 4'($urandom);
         if (addr_i[3:2] == 2'd3 && $urandom_range(0, 7) != 0) wdata_i[0] = 1'b0;
         if (addr_i[3:2] == 2'd1 && $urandom_range(0, 1) != 0) wdata_i[3:0] = 4'hF;
         tick();
      end
      we_i = 1'b0; rst_ni = 1'b1;
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/hex_scan_ctrl.md
Name: hex_scan_ctrl

Overview:
- Memory-mapped controller and scheduler for the 4-digit seven-segment display on the peripheral bus.
- Holds the digit register plus per-digit enable and blink masks, and time-multiplexes the anodes itself.
- Drives the decoded cathode pattern and supports a software soft-clear.
- Replaces the fixed-function display path so software can blank, blink and clear digits.

Parameters:
- SCAN_DIV, 100000, clk_i cycles per digit slot; 1 kHz digit rate at 100 MHz; legal range ≥2.
- BLINK_DIV, 50000000, clk_i cycles per blink half-period; legal range ≥2.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  synchronous active-low reset
- wdata_i  in  32  bus write data
- addr_i  in  32  bus address; only addr_i[3:2] decoded
- be_i  in  4  byte enables
- we_i  in  1  write strobe, one cycle per write
- rdata_o  out  32  registered readback of the register at addr_i
- seg_o  out  7  cathodes {g,f,e,d,c,b,a}, active-low
- an_o  out  4  anodes, active-low, at most one low

Behaviour:
- Reset: synchronous on rising clk_i with rst_ni=0. Reset has priority over all other activity.
  - Register reset values: DIGITS=16'h0, EN=4'hF, BLINK=4'h0.
  - Counters: scan prescaler=0, idx=0, blink counter=0, blink_phase=1 (visible).
  - Outputs: an_o=4'hF, seg_o=7'h7F, rdata_o=0.
- Register map, selected by addr_i[3:2]:
  - 0 DIGITS[15:0]: be_i[0] writes [7:0]; be_i[1] writes [15:8]; be_i[3:2] are ignored. Digit k is DIGITS[4k+3:4k].
  - 1 EN[3:0]: written when be_i[0]=1. EN[k]=0 blanks digit k.
  - 2 BLINK[3:0]: written when be_i[0]=1. BLINK[k]=1 blanks digit k while blink_phase=0.
  - 3 CTRL: writing with be_i[0]=1 and wdata_i[0]=1 performs a soft clear on the next edge.
    - Soft clear returns DIGITS, EN, BLINK, prescaler, idx, blink counter and blink_phase to their reset values.
    - an_o and seg_o then follow normal timing.
    - CTRL is self-clearing and reads 0.
- Writes take effect on the clk_i edge where we_i=1. Writes with we_i=0 or all relevant byte enables 0 have no effect.
- Readback: each cycle, rdata_o <= zero-extended register at addr_i[3:2]. Latency is 1 cycle, independent of we_i.
  - Reading in the same cycle as a write returns the old value; the new value appears one cycle later.
- Scan scheduler:
  - The prescaler counts 0..SCAN_DIV-1 and wraps.
  - On its terminal count, idx advances 0→1→2→3→0 on that edge. The first advance occurs SCAN_DIV cycles after reset.
- Blink timer:
  - The blink counter counts 0..BLINK_DIV-1 and wraps.
  - On its terminal count, blink_phase toggles. The first toggle occurs BLINK_DIV cycles after reset.
- Blanking: blank = !EN[idx] | (BLINK[idx] & !blink_phase).
- Outputs (registered, one cycle after idx and registers):
  - an_o <= blank ? 4'hF : ~(4'b1 << idx)
  - seg_o <= blank ? 7'h7F : hex_decode(digit idx)
  - A register write is visible on seg_o/an_o 2 edges after the write edge (next-state registers, then output registers), provided that digit is currently scanned.
- hex_decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Simultaneous events:
  - A write coinciding with an idx advance: both take effect on the same edge, and the output reflects the new idx with the new data.
  - A soft clear coinciding with terminal counts: the soft clear wins.
  - All EN=0: an_o stays 4'hF; scanning continues internally.
- No combinational path from bus inputs to seg_o, an_o or rdata_o.

Test Plan:
- Reset and digit scan (SCAN_DIV=4, BLINK_DIV=16):
  - Hold rst_ni=0 for 3 cycles → an_o=4'hF, seg_o=7'h7F, rdata_o=0.
  - Release → an_o=1110 with seg_o=1000000, then idx advances every 4 cycles and an_o cycles 1110→1101→1011→0111→1110.
- Decode and byte enables:
  - Write DIGITS=32'h0000A1F8 with be=4'b0011 → read returns 16'hA1F8.
  - Digits 0..3 show 0000000, 0001110, 1111001, 0001000.
  - Then write 32'h00005500 with be=4'b0010 → DIGITS=16'h55F8.
- Enable mask:
  - Write EN=4'b0101 → an_o=4'hF and seg_o=7'h7F during idx 1 and 3 slots.
  - Digits 0 and 2 light normally; reading addr 0x4 returns 32'h5.
- Blink:
  - BLINK=4'b0001, EN=4'hF → digit 0 shows for 16 cycles, is blanked for 16 cycles, and repeats.
  - Digits 1..3 are unaffected.
- Soft clear mid-scan:
  - At idx=2 write CTRL with wdata=1, be=1 → next edge DIGITS=0, EN=F, BLINK=0, idx=0.
  - an_o=1110 and seg_o=1000000 one cycle later; addr 0xC reads 0.
- Reset mid-operation and write/scan collision:
  - Drop rst_ni for one cycle during a blink-off phase → all reset values restored on that edge.
  - A DIGITS write on a scan terminal-count edge appears on the new digit 2 edges after the write.
